// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit two-byte-instruction CPU.
// Fetch FSM states, opcode map and skip condition codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    REQ_OP,
    WAIT_OP,
    REQ_ARG,
    WAIT_ARG,
    HOLD
  } fetch_state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [1:0] SKC_NEG  = 2'b00;
  localparam logic [1:0] SKC_ZERO = 2'b01;
  localparam logic [1:0] SKC_POS  = 2'b10;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads opcode at PC and operand at PC+1 from sync RAM,
// presents them via valid/ready, and takes PC redirects from execute.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_gnt,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_opcode,
  output logic [DATA_WIDTH-1:0] instr_operand,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  issue;
  logic                  accept;
  logic                  cap_op;
  logic                  cap_arg;
  logic                  drop;

  assign accept = instr_valid && instr_ready;

  // Next-state, next-PC and read-issue decode.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    issue      = 1'b0;
    issue_addr = pc;
    cap_op     = 1'b0;
    cap_arg    = 1'b0;
    drop       = 1'b0;
    unique case (state)
      REQ_OP: begin
        if (mem_gnt) begin
          issue     = 1'b1;
          state_nxt = WAIT_OP;
        end
      end
      WAIT_OP: begin
        cap_op    = 1'b1;
        state_nxt = REQ_ARG;
      end
      REQ_ARG: begin
        issue_addr = pc + PC_ONE;
        if (mem_gnt) begin
          issue     = 1'b1;
          state_nxt = WAIT_ARG;
        end
      end
      WAIT_ARG: begin
        cap_arg   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (accept) begin
          drop      = 1'b1;
          pc_nxt    = pc + PC_TWO;
          state_nxt = REQ_OP;
        end
      end
      default: begin
        state_nxt = REQ_OP;
      end
    endcase
    // A redirect squashes whatever is in flight, including a held instruction.
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      state_nxt = REQ_OP;
      issue     = 1'b0;
      cap_op    = 1'b0;
      cap_arg   = 1'b0;
      drop      = 1'b1;
    end
    if (rst) begin
      issue = 1'b0;
    end
  end

  // Memory side: strobes only on issue cycles, address holds otherwise.
  assign mem_cs   = issue;
  assign mem_oe   = issue;
  assign mem_addr = issue ? issue_addr : addr_q;
  assign pc_out   = pc;

  // State register and fetch PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ_OP;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Remember the last issued address so mem_addr is stable between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= issue_addr;
    end
  end

  // Capture the opcode and operand bytes and manage the output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid   <= 1'b0;
      instr_opcode  <= '0;
      instr_operand <= '0;
      instr_pc      <= '0;
    end else begin
      if (cap_op) begin
        instr_opcode <= mem_rdata;
      end
      if (cap_arg) begin
        instr_operand <= mem_rdata;
        instr_pc      <= pc;
        instr_valid   <= 1'b1;
      end else if (drop) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a sync RAM model
// and a scoreboard monitor checking every accepted instruction.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic       mem_cs;
  logic       mem_oe;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_gnt;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] pc_out;

  logic [7:0]  mem [256];
  logic [23:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_addr(mem_addr),
    .mem_cs(mem_cs),
    .mem_oe(mem_oe),
    .mem_rdata(mem_rdata),
    .mem_gnt(mem_gnt),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_opcode(instr_opcode),
    .instr_operand(instr_operand),
    .instr_pc(instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after a read issue.
  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: each accepted instruction must match the queue head.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL sb_unexpected: got %h expected none",
                 {instr_opcode, instr_operand, instr_pc});
      end else begin
        check("sb_instr", {8'h00, instr_opcode, instr_operand, instr_pc},
              {8'h00, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid) break;
    end
    check(name, instr_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h1C;
    mem[8'h18] = 8'h90; mem[8'h19] = 8'h00;
    mem[8'h1A] = 8'h40; mem[8'h1B] = 8'h07;
    mem[8'h40] = 8'hA0; mem[8'h41] = 8'h33;
    mem[8'hFF] = 8'h30;

    rst = 1'b1; mem_gnt = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    check("rst_valid", instr_valid, 0);
    check("rst_opcode", instr_opcode, 0);
    check("rst_operand", instr_operand, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_cs", mem_cs, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_pc", pc_out, 0);

    // Basic fetch with ready high.
    exp_q.push_back({8'h10, 8'h1C, 8'h00});
    instr_ready = 1'b1; rst = 1'b0; #1;
    check("t1_cs0", {mem_cs, mem_oe, mem_addr}, {2'b11, 8'h00});
    tick(); tick();
    check("t1_arg_rd", {mem_cs, mem_addr}, {1'b1, 8'h01});
    tick();
    check("t1_lat3", instr_valid, 0);
    tick();
    check("t1_lat4", instr_valid, 1);
    tick();
    check("t1_next", {mem_cs, mem_addr, pc_out}, {1'b1, 8'h02, 8'h02});
    tick();

    // Reset during WAIT_OP.
    rst = 1'b1;
    tick();
    check("t6_valid", instr_valid, 0);
    check("t6_cs", mem_cs, 0);
    check("t6_pc", pc_out, 0);
    check("t6_opcode", instr_opcode, 0);
    rst = 1'b0; instr_ready = 1'b0; #1;
    check("t6_restart", {mem_cs, mem_addr}, {1'b1, 8'h00});

    // Backpressure in HOLD.
    exp_q.push_back({8'h10, 8'h1C, 8'h00});
    tick(); tick(); tick();
    check("t2_lat3", instr_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold", {instr_valid, instr_opcode, instr_operand, instr_pc},
            {1'b1, 8'h10, 8'h1C, 8'h00});
      check("t2_cs", mem_cs, 0);
      check("t2_pc", pc_out, 0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check("t2_next", {mem_cs, mem_addr}, {1'b1, 8'h02});

    // Redirect during WAIT_ARG.
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 8'h18;
    tick();
    check("t3_novalid", instr_valid, 0);
    check("t3_pc", pc_out, 8'h18);
    redirect_valid = 1'b0;
    exp_q.push_back({8'h90, 8'h00, 8'h18});
    #1;
    check("t3_rd", {mem_cs, mem_addr}, {1'b1, 8'h18});
    wait_valid("t3_wait");
    tick();

    // Grant stall in REQ_ARG.
    exp_q.push_back({8'h40, 8'h07, 8'h1A});
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 2) begin
        mem_gnt = 1'b0; #1;
      end
      if (n >= 2 && n <= 4) check("t4_cs", mem_cs, 0);
      if (n >= 2 && n <= 5) check("t4_op", instr_opcode, 8'h40);
      check("t4_lat", instr_valid, (n == 7) ? 1 : 0);
      if (n == 5) mem_gnt = 1'b1;
    end
    tick();

    // Wrap-around at FF with a redirect in REQ_OP.
    redirect_valid = 1'b1; redirect_pc = 8'hFF; #1;
    check("t5_nord", mem_cs, 0);
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back({8'h30, 8'h10, 8'hFF});
    #1;
    check("t5_rd_op", {mem_cs, mem_addr}, {1'b1, 8'hFF});
    tick(); tick();
    check("t5_rd_arg", {mem_cs, mem_addr}, {1'b1, 8'h00});
    tick(); tick();
    check("t5_valid", instr_valid, 1);
    tick();
    check("t5_pc", pc_out, 8'h01);

    // Redirect in HOLD without handshake drops the instruction.
    instr_ready = 1'b0;
    wait_valid("t7_wait");
    check("t7_ipc", instr_pc, 8'h01);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    check("t7_drop", {instr_valid, pc_out}, {1'b0, 8'h40});
    redirect_valid = 1'b0;

    // Redirect together with a handshake.
    exp_q.push_back({8'hA0, 8'h33, 8'h40});
    wait_valid("t8_wait");
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    check("t8_hs", {instr_valid, pc_out}, {1'b0, 8'h80});
    redirect_valid = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the 8-bit two-byte-instruction CPU, sitting between single_port_sync_ram_large and the decode/execute stage.
- Reads the opcode byte (IRA) at PC and the operand byte (IRB) at PC+1 from the synchronous RAM.
- Presents the assembled instruction to execute through a valid/ready handshake.
- Accepts PC redirects from execute for jump, skip and halt.

Parameters:
- ADDR_WIDTH, 8, RAM address width; PC width.
- DATA_WIDTH, 8, RAM data width; opcode and operand width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- mem_addr  output  ADDR_WIDTH  RAM address (the MAR source during fetch).
- mem_cs  output  1  RAM chip select; high only on read-issue cycles.
- mem_oe  output  1  RAM output enable; high only on read-issue cycles. The fetch unit never writes.
- mem_rdata  input  DATA_WIDTH  RAM read data; valid the cycle after issue.
- mem_gnt  input  1  memory granted to fetch; low while execute owns the RAM for a load, store or add.
- instr_valid  output  1  opcode/operand/pc hold a complete instruction.
- instr_ready  input  1  execute accepts the instruction this cycle.
- instr_opcode  output  DATA_WIDTH  opcode byte; [7:4] is the op, [1:0] is the skip condition.
- instr_operand  output  DATA_WIDTH  operand/address byte.
- instr_pc  output  ADDR_WIDTH  address of the opcode byte.
- redirect_valid  input  1  load a new PC.
- redirect_pc  input  ADDR_WIDTH  target PC.
- pc_out  output  ADDR_WIDTH  current fetch PC.

Behaviour:
- Reset: synchronous; takes effect at the first rising edge with rst=1.
  - State REQ_OP; PC=RESET_PC.
  - instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0.
  - mem_cs=0, mem_oe=0, mem_addr=0.
  - Reset mid-fetch discards any in-flight read.
- State REQ_OP:
  - If mem_gnt=1: drive mem_addr=PC, mem_cs=1, mem_oe=1, then go to WAIT_OP.
  - Else: hold with cs=oe=0.
- State WAIT_OP: opcode register <= mem_rdata, then go to REQ_ARG.
- State REQ_ARG:
  - If mem_gnt=1: drive mem_addr=PC+1 (mod 256), cs=oe=1, then go to WAIT_ARG.
  - Else: hold with cs=oe=0.
- State WAIT_ARG: operand <= mem_rdata; instr_pc <= PC; instr_valid <= 1; go to HOLD.
- State HOLD:
  - Outputs are stable while instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid <= 0, PC <= PC+2 (mod 256), go to REQ_OP.
- Latency: 4 cycles from entering REQ_OP with gnt held high to instr_valid=1. Each gnt-low cycle adds one cycle.
- Redirect (redirect_valid=1) in REQ_OP, WAIT_OP, REQ_ARG or WAIT_ARG:
  - PC <= redirect_pc; state <= REQ_OP.
  - Captured bytes are discarded; instr_valid stays 0.
  - No read is issued in the redirect cycle (cs=0).
- Redirect in HOLD without handshake: instr_valid <= 0 (instruction dropped), PC <= redirect_pc, go to REQ_OP.
- Redirect in HOLD together with instr_ready: the handshake completes, and PC <= redirect_pc rather than PC+2.
- Wrap-around: all PC arithmetic is modulo 2^ADDR_WIDTH.
  - Opcode at 8'hFF takes its operand from 8'h00.
  - Handshake at PC=8'hFE gives next PC 8'h00.
- Halt (PC-2 redirect) and skip (PC+2 redirect) are computed by execute. The fetch unit treats every opcode identically and never decodes.
- No outputs are X after reset. mem_addr holds its last value when cs=0.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_t enum {REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, HOLD}.
  - Opcode constants: OP_LOAD=4'h1, OP_STORE=4'h2, OP_ADD=4'h3, OP_SUB=4'h4, OP_HALT=4'h7, OP_SKIP=4'h8, OP_JUMP=4'h9, OP_CLEAR=4'hA.
  - Skip condition codes: SKC_NEG=2'b00, SKC_ZERO=2'b01, SKC_POS=2'b10.
- Single module. No sub-module is warranted; the top level muxes mem_* between fetch and execute using mem_gnt.

Test Plan:
1. Basic fetch: reset, mem[00]=10, mem[01]=1C, gnt=1, ready=1 -> instr_valid=1 on the 4th cycle after reset release, with opcode=10, operand=1C, instr_pc=00. The next read issues at addr 02.
2. Backpressure: ready=0 for 5 cycles in HOLD -> outputs are constant, mem_cs=0 throughout, and pc_out=00. Raising ready then fetches from 02.
3. Redirect mid-fetch: redirect_valid with redirect_pc=18 asserted during WAIT_ARG -> no valid for the 00 instruction. The next instruction is opcode=90, operand=00, instr_pc=18.
4. Grant stall: gnt=0 for 3 cycles in REQ_ARG -> cs=0 during the stall and the opcode is held. instr_valid rises 7 cycles after fetch start.
5. Wrap: redirect to FF, mem[FF]=30, mem[00]=10 -> opcode=30, operand=10, instr_pc=FF. After the handshake, pc_out=01.
6. Reset mid-operation: rst=1 for one edge during WAIT_OP -> the next cycle shows instr_valid=0, mem_cs=0, pc_out=00, and the fetch restarts from 00.
